instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage directly upstream of the control decoder. It owns the program counter and drives the synchronous instruction ROM. It presents each fetched 9-bit instruction, with a valid flag and its PC, to the decoder and datapath. It consumes the decoder's `Branch` output and redirects through a small writable branch-target lookup table, and it detects the halt encoding.

## Interface

- `PCW`, 10, program counter / ROM address width
- `IW`, 9, instruction width
- `TGTW`, 5, branch-target LUT index width (LUT depth 2^TGTW)
- `HALT_OP`, 9'h1FF, instruction encoding that stops fetch

Ports:
- `Clk`  in  1  single clock, all state on rising edge
- `Reset_n`  in  1  reset, asynchronous, active-low
- `Start`  in  1  begin execution at PC 0 (sampled in IDLE/HALT only)
- `Stall`  in  1  hold current instruction (data-memory busy)
- `Branch`  in  1  branch taken, from control decoder
- `IMemAddr`  out  PCW  ROM read address
- `IMemData`  in  IW  ROM data (registered ROM, 1-cycle latency)
- `Instr`  out  IW  current instruction; equals `IMemData`
- `InstrValid`  out  1  `Instr` is live and must be executed
- `PC`  out  PCW  address of `Instr`
- `Done`  out  1  halt reached
- `LutWe`  in  1  LUT write enable
- `LutAddr`  in  TGTW  LUT write index
- `LutData`  in  PCW  LUT write data

## Operation

- Internal state:
  - `fpc`: next fetch address
  - `PC`: decode PC, a register
  - LUT: 2^TGTW x PCW flops
  - FSM `IDLE`, `RUN`, `HALT`
- Reset (async): FSM=IDLE; `fpc`=0; `PC`=0; `InstrValid`=0; `Done`=0; all LUT entries=0.
- Branch index `BrIdx` = `Instr[TGTW-1:0]`. Target = LUT[BrIdx].
- IMemAddr selection, combinational, in priority order:
  1. IDLE or HALT: 0.
  2. RUN with `Stall`: `PC`.
  3. RUN, valid, `Branch`, not halt: target.
  4. Otherwise: `fpc`.
- IDLE:
  - `Start` -> RUN; `InstrValid`<=1; `PC`<=0; `fpc`<=1.
- RUN (`InstrValid`=1):
  - Halt: `Instr`==HALT_OP and !`Stall`. -> HALT; `Done`<=1; `InstrValid`<=0; `fpc`/`PC` hold. Halt has priority over `Branch`, because HALT_OP decodes as a BR opcode.
  - `Stall`=1: all registers hold; `Branch` ignored. The ROM is re-read at `PC`, so `Instr` stays stable.
  - `Branch`=1: `PC`<=target; `fpc`<=target+1. Zero-bubble redirect.
  - Else: `PC`<=`fpc`; `fpc`<=`fpc`+1.
- HALT:
  - `Done` stays 1.
  - `Start` restarts exactly as from IDLE, and `Done`<=0.
- `Start` in RUN is ignored.
- Arithmetic: `fpc`+1 and target+1 are modulo 2^PCW. 2^PCW-1 wraps to 0 silently.
- LUT write: on an edge with `LutWe`=1, LUT[LutAddr]<=LutData. Writes are allowed in any state. A read in the same cycle as a write to that entry returns the old value.

## Timing

- Start-to-first-instruction: 1 cycle. `Start` is sampled at edge N; `Instr`=ROM[0] and `InstrValid`=1 are valid after edge N.
- Throughput: one instruction per cycle. Branch penalty is 0 cycles. The target instruction is valid the cycle after `Branch` is sampled.
- `Done` rises at the edge following a valid HALT_OP. `InstrValid` falls at the same edge.
- Critical path: ROM out -> decoder -> `Branch` -> LUT mux -> `IMemAddr`. This path is accepted for this core.
- Reset mid-RUN: outputs clear immediately (async). Execution restarts only on a new `Start`.

## Test plan

- Reset then `Start`, ROM[0..3] = non-branch ops, no stall -> `PC` sequence 0,1,2,3 on consecutive cycles; `InstrValid`=1 from the cycle after `Start`.
- LUT[5]=10'd40; ROM[2]=BR with index 5; `Branch`=1 while `PC`=2 -> next cycle `PC`=40, `Instr`=ROM[40]; then `PC`=41.
- `Stall` held 3 cycles while `PC`=7 -> `PC`=7 and `Instr` unchanged for those 3 cycles, with `Branch`=1 injected and ignored; `PC`=8 on the cycle after `Stall` drops.
- ROM[4]=9'h1FF with `Branch`=1 -> next cycle `Done`=1 and `InstrValid`=0; `Done` holds; `Start` -> `Done`=0 and `PC`=0.
- Branch to LUT entry 10'h3FF, next op sequential -> `PC`=3FF then 0 (wrap).
- `Reset_n` asserted low mid-RUN between edges -> `InstrValid`, `Done`, `PC` go to 0 without a clock edge; LUT entries read 0 afterwards.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives a registered instruction ROM,
// redirects on Branch through a writable branch-target LUT and stops on HALT_OP.
module instr_fetch #(
  parameter int unsigned    PCW     = 10,
  parameter int unsigned    IW      = 9,
  parameter int unsigned    TGTW    = 5,
  parameter logic [IW-1:0]  HALT_OP = 9'h1FF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Branch,
  output logic [PCW-1:0]  IMemAddr,
  input  logic [IW-1:0]   IMemData,
  output logic [IW-1:0]   Instr,
  output logic            InstrValid,
  output logic [PCW-1:0]  PC,
  output logic            Done,
  input  logic            LutWe,
  input  logic [TGTW-1:0] LutAddr,
  input  logic [PCW-1:0]  LutData
);

  localparam int unsigned DEPTH = 1 << TGTW;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] fpc;
  logic [PCW-1:0] lut [DEPTH];
  logic [PCW-1:0] target;
  logic           running;
  logic           start_go;
  logic           halt_hit;
  logic           branch_take;

  assign Instr       = IMemData;
  assign target      = lut[Instr[TGTW-1:0]];
  assign running     = (state == RUN) && InstrValid;
  assign start_go    = (state != RUN) && Start;
  // Halt wins over Branch: the halt encoding also decodes as a branch opcode.
  assign halt_hit    = running && !Stall && (Instr == HALT_OP);
  assign branch_take = running && !Stall && Branch && (Instr != HALT_OP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start)    state_nxt = RUN;
      RUN:     if (halt_hit) state_nxt = HALT;
      HALT:    if (Start)    state_nxt = RUN;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    IMemAddr = fpc;
    if (state != RUN)     IMemAddr = '0;
    else if (Stall)       IMemAddr = PC;
    else if (branch_take) IMemAddr = target;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fpc        <= '0;
      PC         <= '0;
      InstrValid <= 1'b0;
      Done       <= 1'b0;
    end else if (start_go) begin
      PC         <= '0;
      fpc        <= PCW'(1);
      InstrValid <= 1'b1;
      Done       <= 1'b0;
    end else if (halt_hit) begin
      InstrValid <= 1'b0;
      Done       <= 1'b1;
    end else if (branch_take) begin
      PC  <= target;
      fpc <= target + PCW'(1);
    end else if (running && !Stall) begin
      PC  <= fpc;
      fpc <= fpc + PCW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (LutWe) begin
      lut[LutAddr] <= LutData;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: registered ROM model, table of per-cycle
// vectors with hand-computed PC / address / flag expectations, plus reset cases.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stall = 1'b0, branch = 1'b0;
  logic [9:0] imem_addr;
  logic [8:0] imem_data = '0;
  logic [8:0] instr;
  logic       instr_valid;
  logic [9:0] pc;
  logic       done;
  logic       lut_we = 1'b0;
  logic [4:0] lut_addr = '0;
  logic [9:0] lut_data = '0;

  logic [8:0] rom [1024];
  int checks = 0;
  int errors = 0;

  instr_fetch #(.PCW(10), .IW(9), .TGTW(5), .HALT_OP(9'h1FF)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Stall(stall), .Branch(branch),
    .IMemAddr(imem_addr), .IMemData(imem_data), .Instr(instr),
    .InstrValid(instr_valid), .PC(pc), .Done(done),
    .LutWe(lut_we), .LutAddr(lut_addr), .LutData(lut_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  typedef struct {
    logic       start, stall, branch, we;
    logic [4:0] waddr;
    logic [9:0] wdata;
    logic [9:0] addr;
    logic [9:0] pc;
    logic       valid, done;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic st, input logic sl, input logic br,
                              input logic we, input logic [4:0] wa, input logic [9:0] wd,
                              input logic [9:0] ad, input logic [9:0] p,
                              input logic v, input logic d);
    vec_t r;
    r.start = st; r.stall = sl; r.branch = br; r.we = we; r.waddr = wa; r.wdata = wd;
    r.addr = ad; r.pc = p; r.valid = v; r.done = d;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    start = v.start; stall = v.stall; branch = v.branch;
    lut_we = v.we; lut_addr = v.waddr; lut_data = v.wdata;
    #1 check("imem_addr", idx, 32'(imem_addr), 32'(v.addr));
    @(posedge clk);
    #1;
    check("pc",    idx, 32'(pc),          32'(v.pc));
    check("valid", idx, 32'(instr_valid), 32'(v.valid));
    check("done",  idx, 32'(done),        32'(v.done));
    if (v.valid) check("instr", idx, 32'(instr), 32'(rom[v.pc]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 7 + 3) & 8'hFF);
    rom[2]  = 9'h105;  // branch opcode, LUT index 5
    rom[4]  = 9'h1FF;  // halt
    rom[9]  = 9'h103;  // branch opcode, LUT index 3
    rom[41] = 9'h106;  // branch opcode, LUT index 6

    //            st sl br we wa  wdata     addr     pc     v  d
    tbl[0]  = mk(0, 0, 0, 1, 5, 10'd40,  10'd0,   10'd0,   0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 6, 10'd7,   10'd0,   10'd0,   0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 3, 10'h3FF, 10'd0,   10'd0,   0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 10'd0,   10'd0,   10'd0,   1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 10'd0,   10'd1,   10'd1,   1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 10'd0,   10'd2,   10'd2,   1, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0, 10'd0,   10'd40,  10'd40,  1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 10'd0,   10'd41,  10'd41,  1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 10'd0,   10'd7,   10'd7,   1, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 10'd0,   10'd7,   10'd7,   1, 0);
    tbl[10] = mk(0, 1, 1, 0, 0, 10'd0,   10'd7,   10'd7,   1, 0);
    tbl[11] = mk(0, 1, 1, 0, 0, 10'd0,   10'd7,   10'd7,   1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 10'd0,   10'd8,   10'd8,   1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 10'd0,   10'd9,   10'd9,   1, 0);
    tbl[14] = mk(0, 0, 1, 1, 3, 10'h155, 10'h3FF, 10'h3FF, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 10'd0,   10'd0,   10'd0,   1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 10'd0,   10'd1,   10'd1,   1, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 10'd0,   10'd2,   10'd2,   1, 0);
    tbl[18] = mk(1, 0, 0, 0, 0, 10'd0,   10'd3,   10'd3,   1, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 10'd0,   10'd4,   10'd4,   1, 0);
    tbl[20] = mk(0, 1, 1, 0, 0, 10'd0,   10'd4,   10'd4,   1, 0);
    tbl[21] = mk(0, 0, 1, 0, 0, 10'd0,   10'd5,   10'd4,   0, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 10'd0,   10'd0,   10'd4,   0, 1);
    tbl[23] = mk(1, 0, 0, 0, 0, 10'd0,   10'd0,   10'd0,   1, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 10'd0,   10'd1,   10'd1,   1, 0);

    #12;
    check("reset_pc",    0, 32'(pc),          32'd0);
    check("reset_valid", 0, 32'(instr_valid), 32'd0);
    check("reset_done",  0, 32'(done),        32'd0);
    check("reset_addr",  0, 32'(imem_addr),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) apply(tbl[i], i);

    // Asynchronous reset in the middle of a cycle while running.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pc",    100, 32'(pc),          32'd0);
    check("async_valid", 100, 32'(instr_valid), 32'd0);
    check("async_done",  100, 32'(done),        32'd0);
    check("async_addr",  100, 32'(imem_addr),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("async_stays_idle", 101, 32'(instr_valid), 32'd0);

    // After reset the LUT is cleared: branching via index 5 now lands on 0.
    apply(mk(1, 0, 0, 0, 0, 10'd0, 10'd0, 10'd0, 1, 0), 102);
    apply(mk(0, 0, 0, 0, 0, 10'd0, 10'd1, 10'd1, 1, 0), 103);
    apply(mk(0, 0, 0, 0, 0, 10'd0, 10'd2, 10'd2, 1, 0), 104);
    apply(mk(0, 0, 1, 0, 0, 10'd0, 10'd0, 10'd0, 1, 0), 105);
    apply(mk(0, 0, 0, 0, 0, 10'd0, 10'd1, 10'd1, 1, 0), 106);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
